// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/execute requesters and the shared memory.
// master: arbiter side. slave: requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int width = 32
);
    logic             if_req;
    logic [width-1:0] if_addr;
    logic [width-1:0] if_rdata;
    logic             if_ack;
    logic             d_req;
    logic             d_we;
    logic [1:0]       d_size;
    logic [width-1:0] d_addr;
    logic [width-1:0] d_wdata;
    logic [width-1:0] d_rdata;
    logic             d_ack;
    logic             mem_req;
    logic             mem_we;
    logic [1:0]       mem_size;
    logic [width-1:0] mem_addr;
    logic [width-1:0] mem_wdata;
    logic [width-1:0] mem_rdata;
    logic             mem_ack;
    logic             stall_if;
    logic             stall_ex;
    logic             err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_size, mem_addr,
        output mem_wdata, stall_if, stall_ex, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_size, mem_addr,
        input  mem_wdata, stall_if, stall_ex, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and load/store (D).
// Define MEM_ARB_FAIRNESS_EN to force an I grant after STARVE_LIMIT consecutive D grants.
module mem_port_arbiter #(
    parameter int width        = 32,
    parameter int MAX_WAIT     = 255,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t           state;
    logic             mem_req_p1;
    logic             mem_we_p1;
    logic [1:0]       mem_size_p1;
    logic [width-1:0] mem_addr_p1;
    logic [width-1:0] mem_wdata_p1;
    logic [width-1:0] if_rdata_p1;
    logic [width-1:0] d_rdata_p1;
    logic             if_ack_p1;
    logic             d_ack_p1;
    logic             err_p1;
    logic [7:0]       wait_cnt;
    logic             force_i;
    logic             grant_d;
    logic             done_now;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    assign force_i = bus.if_req && (starve_cnt == STARVE_MAX);

    // Counts D grants won while fetch sits waiting; any I grant or idle fetch restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.if_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d) starve_cnt <= starve_cnt + 1'b1;
            else         starve_cnt <= '0;
        end
    end
`else
    logic unused_starve_cfg;

    // The starvation limit only has meaning when fairness is compiled in.
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
    assign force_i           = 1'b0;
`endif

    assign grant_d  = bus.d_req && !force_i;
    assign done_now = bus.mem_ack || (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mem_req_p1   <= 1'b0;
            mem_we_p1    <= 1'b0;
            mem_size_p1  <= 2'b00;
            mem_addr_p1  <= '0;
            mem_wdata_p1 <= '0;
            if_rdata_p1  <= '0;
            d_rdata_p1   <= '0;
            if_ack_p1    <= 1'b0;
            d_ack_p1     <= 1'b0;
            err_p1       <= 1'b0;
            wait_cnt     <= 8'd0;
        end else begin
            if_ack_p1 <= 1'b0;
            d_ack_p1  <= 1'b0;
            err_p1    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req_p1   <= 1'b1;
                        mem_we_p1    <= bus.d_we;
                        mem_size_p1  <= bus.d_size;
                        mem_addr_p1  <= bus.d_addr;
                        mem_wdata_p1 <= bus.d_wdata;
                        wait_cnt     <= 8'd0;
                        state        <= BUSY_D;
                    end else if (bus.if_req) begin
                        mem_req_p1   <= 1'b1;
                        mem_we_p1    <= 1'b0;
                        mem_size_p1  <= 2'b10;
                        mem_addr_p1  <= bus.if_addr;
                        mem_wdata_p1 <= '0;
                        wait_cnt     <= 8'd0;
                        state        <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A real ack beats a timeout landing on the same cycle.
                    if (done_now) begin
                        mem_req_p1 <= 1'b0;
                        err_p1     <= !bus.mem_ack;
                        state      <= DONE;
                        if (state == BUSY_I) begin
                            if_ack_p1   <= 1'b1;
                            if_rdata_p1 <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            d_ack_p1   <= 1'b1;
                            d_rdata_p1 <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_p1;
    assign bus.mem_we    = mem_we_p1;
    assign bus.mem_size  = mem_size_p1;
    assign bus.mem_addr  = mem_addr_p1;
    assign bus.mem_wdata = mem_wdata_p1;
    assign bus.if_rdata  = if_rdata_p1;
    assign bus.d_rdata   = d_rdata_p1;
    assign bus.if_ack    = if_ack_p1;
    assign bus.d_ack     = d_ack_p1;
    assign bus.err       = err_p1;
    assign bus.stall_if  = bus.if_req & ~if_ack_p1;
    assign bus.stall_ex  = bus.d_req & ~d_ack_p1;

endmodule
